mac_seq: RTL
============

# mac_seq

Job sequencer for the `mac` datapath, instantiated beside it in the `mac_sys` wrapper.
- Accepts a dot-product job descriptor, streams operand pairs into the MAC, and drives the accumulate/saturate instruction sequence and the `stall` input.
- Drains the MAC's 2-stage pipeline and captures the accumulated result.
- Presents that result on a valid/ready response port.

## Interface
- LEN_W, 8, width of job length (elements per job, 0..2^LEN_W-1)
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- job_valid  in  1  job descriptor valid
- job_ready  out  1  sequencer idle, descriptor accepted on valid&ready
- job_mode  in  1  0 = one 16x16 MAC, 1 = dual 8x8 MAC
- job_sat  in  1  apply saturate instruction after last element
- job_len  in  LEN_W  element count
- op_valid  in  1  operand pair valid
- op_ready  out  1  operand pair consumed on valid&ready
- op_a, op_b  in  16  operands (dual mode: [15:8] hi lane, [7:0] lo lane)
- mac_instruction  out  3  to mac
- mac_multiplier, mac_multiplicand  out  16  to mac
- mac_stall  out  1  to mac
- mac_result  in  32  from mac
- mac_protect  in  8  from mac
- res_valid  out  1  response valid
- res_ready  in  1  response accepted
- res_data  out  32  captured result
- res_guard  out  8  captured guard bits

## Operation
- MAC instruction encodings:
  - 16-bit: 000 clear, 001 load product, 010 accumulate, 011 saturate.
  - 8-bit: 100, 101, 110, 111 for the same four operations.
  - `m` below is the mode offset: 0 for 16-bit, 4 for dual 8-bit.
- FSM states and transitions:
  - IDLE: job_ready=1. On accept, latch mode, sat and len, then:
    - go to ISSUE if len≠0;
    - go to ZERO if len=0.
  - ISSUE: op_ready=1.
    - On op_valid: drive op_a/op_b to the MAC with stall=0 and instruction m+001 for element 0, m+010 for later elements; increment the element counter.
    - On !op_valid: stall=1, operands and instruction held, counter held.
    - After the last element: go to SAT if sat, else DRAIN1.
  - ZERO: instruction m+000, stall=0, one cycle, then DRAIN1.
  - SAT: instruction m+011, stall=0, one cycle, then DRAIN1.
  - DRAIN1, DRAIN2: instruction 000, stall=0, one cycle each.
  - CAP: stall=1; register mac_result→res_data and mac_protect→res_guard; go to RESP.
  - RESP: res_valid=1 until res_ready, then IDLE.
- Outside ISSUE/ZERO/SAT/DRAINx: mac_stall=1, mac_instruction=000, operands 0.
- Drain semantics: the 000 issued in DRAINx clears the MAC accumulators after the final result has been written, so the next job starts clean.
- Guard bits:
  - With sat, res_guard holds the pre-saturation guard bits, because the MAC's saturate instruction does not update protect.
  - Dual mode: res_guard[7:4] is the hi lane, [3:0] the lo lane.
- res_data and res_guard hold their value from CAP until the next CAP.
- Reset (any state, including mid-job): go to IDLE; the partial job is discarded.
  - Outputs during and after reset: job_ready=0 while reset_n=0, op_ready=0, res_valid=0, res_data=0, res_guard=0, mac_instruction=000, operands 0, mac_stall=1.

## Timing
- MAC latency: an instruction issued in cycle c (stall=0) appears on mac_result in cycle c+3.
- Accept in cycle 0 with op_valid held high: ISSUE occupies cycles 1..N, SAT (if any) one cycle, DRAIN1/DRAIN2/CAP follow, and res_valid rises in cycle N+S+4, where S = job_sat.
- len=0 behaves like N=1 and returns 0.
- Each op_valid-low cycle during ISSUE delays completion by exactly one cycle.
- job_ready and op_ready are decoded combinationally from state; res_valid is registered.
- No new job is accepted while res_valid=1.

## Structure
- Shared package mac_pkg: the eight instruction encoding constants and the sequencer state enum.
- Single module, no sub-module.

## Test plan
- 16-bit, len 3, no sat, pairs (3,4), (−2,5), (100,−7) -> res_data 0xFFFFFD46, res_guard 0xFF, res_valid in cycle 7.
- 16-bit, sat, len 3 of (0x7FFF,0x7FFF) -> res_data 0x7FFFFFFF, res_guard 0x00, res_valid in cycle 8.
- Dual 8-bit, len 2 of (0x7F80,0x7F80):
  - no sat -> res_data 0x7E028000, res_guard 0x00;
  - sat -> res_data 0x7E027FFF.
- Case 1 with op_valid low for 2 cycles between elements -> mac_stall high exactly those cycles, same result, res_valid in cycle 9.
- len 0 -> res_data 0, res_guard 0. Then res_ready held low 5 cycles -> res_valid and res_data stable and job_ready low throughout; next job accepted in the cycle after res handshake completes plus IDLE.
- reset_n low mid-ISSUE -> next cycle IDLE, all outputs at reset values; a subsequent case-1 job returns 0xFFFFFD46 (no residue from the aborted job).

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the mac datapath and its job sequencer:
// instruction encodings, operation selector and sequencer state.
package mac_pkg;

  // 16-bit single-lane instructions
  localparam logic [2:0] MAC_CLR16  = 3'b000;
  localparam logic [2:0] MAC_LOAD16 = 3'b001;
  localparam logic [2:0] MAC_ACC16  = 3'b010;
  localparam logic [2:0] MAC_SAT16  = 3'b011;
  // dual 8-bit lane instructions
  localparam logic [2:0] MAC_CLR8   = 3'b100;
  localparam logic [2:0] MAC_LOAD8  = 3'b101;
  localparam logic [2:0] MAC_ACC8   = 3'b110;
  localparam logic [2:0] MAC_SAT8   = 3'b111;

  typedef enum logic [1:0] {
    OP_CLR,
    OP_LOAD,
    OP_ACC,
    OP_SAT
  } mac_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ZERO,
    ST_SAT,
    ST_DRAIN1,
    ST_DRAIN2,
    ST_CAP,
    ST_RESP
  } seq_state_e;

  // Maps an operation to its encoding in the selected lane mode.
  function automatic logic [2:0] mac_instr(input logic dual, input mac_op_e op);
    logic [2:0] instr;
    case (op)
      OP_CLR:  instr = dual ? MAC_CLR8  : MAC_CLR16;
      OP_LOAD: instr = dual ? MAC_LOAD8 : MAC_LOAD16;
      OP_ACC:  instr = dual ? MAC_ACC8  : MAC_ACC16;
      default: instr = dual ? MAC_SAT8  : MAC_SAT16;
    endcase
    return instr;
  endfunction

endpackage

// File: rtl/mac_seq.sv
// Job sequencer for the mac datapath: accepts a dot-product descriptor,
// streams operand pairs into the MAC, drains its pipeline, captures the
// accumulated result and returns it on a valid/ready response port.
module mac_seq
  import mac_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic             job_mode,
  input  logic             job_sat,
  input  logic [LEN_W-1:0] job_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic [2:0]       mac_instruction,
  output logic [15:0]      mac_multiplier,
  output logic [15:0]      mac_multiplicand,
  output logic             mac_stall,
  input  logic [31:0]      mac_result,
  input  logic [7:0]       mac_protect,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [7:0]       res_guard
);

  seq_state_e       state_q, state_d;
  logic             mode_q, mode_d;
  logic             sat_q, sat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      hold_a_q, hold_a_d;
  logic [15:0]      hold_b_q, hold_b_d;
  logic [2:0]       hold_instr_q, hold_instr_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [7:0]       res_guard_q, res_guard_d;

  logic             last_elem;
  logic [2:0]       issue_instr;

  // Element 0 loads the product, later elements accumulate onto it.
  assign issue_instr = mac_instr(mode_q, (cnt_q == '0) ? OP_LOAD : OP_ACC);
  assign last_elem   = (cnt_q == len_q - LEN_W'(1));

  // Next-state and next-register computation for the job sequence.
  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves it
    // unassigned; a missed assignment here would infer a latch.
    state_d      = state_q;
    mode_d       = mode_q;
    sat_d        = sat_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    hold_a_d     = hold_a_q;
    hold_b_d     = hold_b_q;
    hold_instr_d = hold_instr_q;
    res_data_d   = res_data_q;
    res_guard_d  = res_guard_q;

    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          mode_d       = job_mode;
          sat_d        = job_sat;
          len_d        = job_len;
          cnt_d        = '0;
          hold_a_d     = '0;
          hold_b_d     = '0;
          hold_instr_d = MAC_CLR16;
          state_d      = (job_len == '0) ? ST_ZERO : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_valid) begin
          hold_a_d     = op_a;
          hold_b_d     = op_b;
          hold_instr_d = issue_instr;
          cnt_d        = cnt_q + LEN_W'(1);
          if (last_elem) begin
            state_d = sat_q ? ST_SAT : ST_DRAIN1;
          end
        end
      end
      ST_ZERO:   state_d = ST_DRAIN1;
      ST_SAT:    state_d = ST_DRAIN1;
      ST_DRAIN1: state_d = ST_DRAIN2;
      ST_DRAIN2: state_d = ST_CAP;
      ST_CAP: begin
        // The last issued instruction lands on mac_result in this cycle.
        res_data_d  = mac_result;
        res_guard_d = mac_protect;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    res_valid_d = (state_d == ST_RESP);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block and
    // kept out of the sensitivity list; all state uses <= so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      sat_q        <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      hold_a_q     <= '0;
      hold_b_q     <= '0;
      hold_instr_q <= MAC_CLR16;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_guard_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      sat_q        <= sat_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      hold_a_q     <= hold_a_d;
      hold_b_q     <= hold_b_d;
      hold_instr_q <= hold_instr_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_guard_q  <= res_guard_d;
    end
  end

  // Handshakes and MAC drive decoded from state; everything is forced to its
  // idle value while reset_n is low, even before the reset edge arrives.
  always_comb begin
    job_ready        = 1'b0;
    op_ready         = 1'b0;
    mac_stall        = 1'b1;
    mac_instruction  = MAC_CLR16;
    mac_multiplier   = '0;
    mac_multiplicand = '0;

    if (reset_n) begin
      case (state_q)
        ST_IDLE: job_ready = 1'b1;
        ST_ISSUE: begin
          op_ready = 1'b1;
          if (op_valid) begin
            mac_stall        = 1'b0;
            mac_instruction  = issue_instr;
            mac_multiplier   = op_a;
            mac_multiplicand = op_b;
          end else begin
            mac_instruction  = hold_instr_q;
            mac_multiplier   = hold_a_q;
            mac_multiplicand = hold_b_q;
          end
        end
        ST_ZERO: begin
          mac_stall       = 1'b0;
          mac_instruction = mac_instr(mode_q, OP_CLR);
        end
        ST_SAT: begin
          mac_stall       = 1'b0;
          mac_instruction = mac_instr(mode_q, OP_SAT);
        end
        ST_DRAIN1, ST_DRAIN2: begin
          // A full clear lands after the result is captured, so the next job
          // starts from empty accumulators in either lane mode.
          mac_stall       = 1'b0;
          mac_instruction = MAC_CLR16;
        end
        default: ;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_guard = res_guard_q;

endmodule
